// File: rtl/mu0_pkg.sv
// Shared encodings for the MU0 control unit: ALU operations, instruction
// opcodes, FSM states and the control word produced by the decoder.
package mu0_pkg;

    typedef enum logic [3:0] {
        ALU_ZERO  = 4'd0,
        ALU_ADD   = 4'd1,
        ALU_SUB   = 4'd2,
        ALU_A_INC = 4'd3,
        ALU_B     = 4'd4
    } alu_op_e;

    typedef enum logic [3:0] {
        OP_LDA = 4'd0,
        OP_STO = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_JMP = 4'd4,
        OP_JGE = 4'd5,
        OP_JNE = 4'd6,
        OP_STP = 4'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // done: the current state finishes this cycle; stop: the finishing op is STP.
    typedef struct packed {
        alu_op_e alu_op;
        logic    a_sel;
        logic    b_sel;
        logic    addr_sel;
        logic    mem_req;
        logic    mem_we;
        logic    ir_en;
        logic    pc_en;
        logic    acc_en;
        logic    halted;
        logic    done;
        logic    stop;
    } ctrl_t;

endpackage

// File: rtl/mu0_decode.sv
// Combinational decode of FSM state, opcode, memory handshake and ACC flags
// into the datapath control word.
module mu0_decode
    import mu0_pkg::*;
(
    input  state_e     state_i,
    input  logic [3:0] ir_opcode_i,
    input  logic       mem_ack_i,
    input  logic       acc_zero_i,
    input  logic       acc_neg_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        // NOTE: every field is defaulted before the case so no path can infer a latch.
        ctrl_o        = '0;
        ctrl_o.alu_op = ALU_ZERO;

        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.a_sel   = 1'b1;
                ctrl_o.alu_op  = ALU_A_INC;
                ctrl_o.ir_en   = mem_ack_i;
                ctrl_o.pc_en   = mem_ack_i;
                ctrl_o.done    = mem_ack_i;
            end

            ST_EXEC: begin
                case (ir_opcode_i)
                    OP_LDA: begin
                        ctrl_o.mem_req  = 1'b1;
                        ctrl_o.addr_sel = 1'b1;
                        ctrl_o.alu_op   = ALU_B;
                        ctrl_o.acc_en   = mem_ack_i;
                        ctrl_o.done     = mem_ack_i;
                    end
                    OP_STO: begin
                        ctrl_o.mem_req  = 1'b1;
                        ctrl_o.mem_we   = 1'b1;
                        ctrl_o.addr_sel = 1'b1;
                        ctrl_o.done     = mem_ack_i;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl_o.mem_req  = 1'b1;
                        ctrl_o.addr_sel = 1'b1;
                        ctrl_o.alu_op   = (ir_opcode_i == OP_SUB) ? ALU_SUB : ALU_ADD;
                        ctrl_o.acc_en   = mem_ack_i;
                        ctrl_o.done     = mem_ack_i;
                    end
                    // Jumps load PC from IR[11:0] through the ALU B path.
                    OP_JMP, OP_JGE, OP_JNE: begin
                        ctrl_o.b_sel  = 1'b1;
                        ctrl_o.alu_op = ALU_B;
                        ctrl_o.done   = 1'b1;
                        if (ir_opcode_i == OP_JGE)
                            ctrl_o.pc_en = ~acc_neg_i;
                        else if (ir_opcode_i == OP_JNE)
                            ctrl_o.pc_en = ~acc_zero_i;
                        else
                            ctrl_o.pc_en = 1'b1;
                    end
                    OP_STP: begin
                        ctrl_o.done = 1'b1;
                        ctrl_o.stop = 1'b1;
                    end
                    default: begin
                        ctrl_o.done = 1'b1;
                    end
                endcase
            end

            ST_HALT: begin
                ctrl_o.halted = 1'b1;
            end

            default: ;
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit: FETCH/EXEC/HALT sequencer and retired-instruction counter;
// all control outputs come combinationally from mu0_decode.
module mu0_control
    import mu0_pkg::*;
#(
    parameter logic [15:0] INSTR_COUNT_RST = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ir_opcode,
    input  logic        mem_ack,
    input  logic        acc_zero,
    input  logic        acc_neg,
    output logic [3:0]  alu_op,
    output logic        a_sel,
    output logic        b_sel,
    output logic        addr_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_en,
    output logic        pc_en,
    output logic        acc_en,
    output logic        halted,
    output logic [15:0] instr_count
);

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    ctrl_t       ctrl;

    mu0_decode u_decode (
        .state_i     (state_q),
        .ir_opcode_i (ir_opcode),
        .mem_ack_i   (mem_ack),
        .acc_zero_i  (acc_zero),
        .acc_neg_i   (acc_neg),
        .ctrl_o      (ctrl)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_FETCH: if (ctrl.done) state_d = ST_EXEC;
            ST_EXEC: begin
                if (ctrl.done) begin
                    state_d = ctrl.stop ? ST_HALT : ST_FETCH;
                    count_d = count_q + 16'd1;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            count_q <= INSTR_COUNT_RST;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Reset holds the FETCH decode visible but must never let a load enable pulse.
    assign ir_en       = ctrl.ir_en  & ~rst;
    assign pc_en       = ctrl.pc_en  & ~rst;
    assign acc_en      = ctrl.acc_en & ~rst;
    assign alu_op      = ctrl.alu_op;
    assign a_sel       = ctrl.a_sel;
    assign b_sel       = ctrl.b_sel;
    assign addr_sel    = ctrl.addr_sel;
    assign mem_req     = ctrl.mem_req;
    assign mem_we      = ctrl.mem_we;
    assign halted      = ctrl.halted;
    assign instr_count = count_q;

endmodule

// File: tb/tb_mu0_control.sv
// Scoreboard bench for mu0_control: stimulus pushes hand-computed expected
// control words; a negedge monitor pops and compares them.
module tb_mu0_control;

    logic        clk = 1'b1;
    logic        rst = 1'b1;
    logic [3:0]  ir_opcode = 4'd0;
    logic        mem_ack = 1'b0, acc_zero = 1'b0, acc_neg = 1'b0;
    logic [3:0]  alu_op;
    logic        a_sel, b_sel, addr_sel, mem_req, mem_we;
    logic        ir_en, pc_en, acc_en, halted;
    logic [15:0] instr_count;

    // Second instance preloaded near the counter limit for the wrap check.
    logic        rst_w = 1'b1;
    logic [3:0]  w_alu_op;
    logic        w_a_sel, w_b_sel, w_addr_sel, w_mem_req, w_mem_we;
    logic        w_ir_en, w_pc_en, w_acc_en, w_halted;
    logic [15:0] w_count;

    always #5 clk = ~clk;

    mu0_control dut (
        .clk(clk), .rst(rst), .ir_opcode(ir_opcode), .mem_ack(mem_ack),
        .acc_zero(acc_zero), .acc_neg(acc_neg), .alu_op(alu_op),
        .a_sel(a_sel), .b_sel(b_sel), .addr_sel(addr_sel), .mem_req(mem_req),
        .mem_we(mem_we), .ir_en(ir_en), .pc_en(pc_en), .acc_en(acc_en),
        .halted(halted), .instr_count(instr_count)
    );

    mu0_control #(.INSTR_COUNT_RST(16'hFFFD)) dut_wrap (
        .clk(clk), .rst(rst_w), .ir_opcode(4'd9), .mem_ack(1'b1),
        .acc_zero(1'b0), .acc_neg(1'b0), .alu_op(w_alu_op),
        .a_sel(w_a_sel), .b_sel(w_b_sel), .addr_sel(w_addr_sel), .mem_req(w_mem_req),
        .mem_we(w_mem_we), .ir_en(w_ir_en), .pc_en(w_pc_en), .acc_en(w_acc_en),
        .halted(w_halted), .instr_count(w_count)
    );

    typedef struct packed {
        logic [3:0]  alu_op;
        logic        a_sel, b_sel, addr_sel, mem_req, mem_we;
        logic        ir_en, pc_en, acc_en, halted;
        logic [15:0] cnt;
    } obs_t;

    typedef struct {
        obs_t  e;
        string nm;
    } item_t;

    item_t       q[$];
    logic [15:0] wq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    obs_t        act;

    assign act = {alu_op, a_sel, b_sel, addr_sel, mem_req, mem_we,
                  ir_en, pc_en, acc_en, halted, instr_count};

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (alu,a,b,addr,req,we,ir,pc,acc,halt,cnt)",
                     nm, got, exp);
        end
    endtask

    function automatic obs_t ev(input logic [3:0] alu, input logic a, input logic b,
                                input logic addr, input logic req, input logic we,
                                input logic ir, input logic pc, input logic acc,
                                input logic halt, input logic [15:0] cnt);
        return {alu, a, b, addr, req, we, ir, pc, acc, halt, cnt};
    endfunction

    function automatic obs_t fetch_wait(input logic [15:0] cnt);
        return ev(4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cnt);
    endfunction

    function automatic obs_t fetch_ack(input logic [15:0] cnt);
        return ev(4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, cnt);
    endfunction

    function automatic obs_t sto_exec(input logic [15:0] cnt);
        return ev(4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cnt);
    endfunction

    // Apply one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input logic r, input logic [3:0] op, input logic ack,
                        input logic z, input logic n, input obs_t e, input string nm);
        item_t it;
        rst       = r;
        ir_opcode = op;
        mem_ack   = ack;
        acc_zero  = z;
        acc_neg   = n;
        it.e  = e;
        it.nm = nm;
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                it = q.pop_front();
                check(it.nm, {3'b0, act}, {3'b0, it.e});
            end
            if (wq.size() > 0)
                check("wrap_count", {16'h0, w_count}, {16'h0, wq.pop_front()});
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [15:0] wrap_exp [7];
        wrap_exp = '{16'hFFFD, 16'hFFFD, 16'hFFFE, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'h0000};
        #1;
        // Reset shows FETCH decode with enables masked even when mem_ack is high.
        step(1, 4'd0, 1, 0, 0, fetch_wait(0), "rst_masked");
        step(1, 4'd0, 1, 0, 0, fetch_wait(0), "rst_masked2");

        // LDA with zero-wait memory.
        step(0, 4'd0, 1, 0, 0, fetch_ack(0), "lda_fetch");
        step(0, 4'd0, 1, 0, 0, ev(4, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0), "lda_exec");

        // ADD with the ack delayed by three cycles.
        step(0, 4'd2, 1, 0, 0, fetch_ack(1), "add_fetch");
        for (int i = 0; i < 3; i++)
            step(0, 4'd2, 0, 0, 0, ev(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1), "add_wait");
        step(0, 4'd2, 1, 0, 0, ev(1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1), "add_ack");

        step(0, 4'd3, 1, 0, 0, fetch_ack(2), "sub_fetch");
        step(0, 4'd3, 1, 0, 0, ev(2, 0, 0, 1, 1, 0, 0, 0, 1, 0, 2), "sub_exec");

        // Conditional and unconditional jumps, one cycle each.
        step(0, 4'd6, 1, 1, 0, fetch_ack(3), "jne_z_fetch");
        step(0, 4'd6, 0, 1, 0, ev(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3), "jne_z_exec");
        step(0, 4'd6, 1, 0, 0, fetch_ack(4), "jne_nz_fetch");
        step(0, 4'd6, 0, 0, 0, ev(4, 0, 1, 0, 0, 0, 0, 1, 0, 0, 4), "jne_nz_exec");
        step(0, 4'd5, 1, 0, 1, fetch_ack(5), "jge_neg_fetch");
        step(0, 4'd5, 0, 0, 1, ev(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5), "jge_neg_exec");
        step(0, 4'd5, 1, 0, 0, fetch_ack(6), "jge_pos_fetch");
        step(0, 4'd5, 0, 0, 0, ev(4, 0, 1, 0, 0, 0, 0, 1, 0, 0, 6), "jge_pos_exec");
        step(0, 4'd4, 1, 1, 1, fetch_ack(7), "jmp_fetch");
        step(0, 4'd4, 1, 1, 1, ev(4, 0, 1, 0, 0, 0, 0, 1, 0, 0, 7), "jmp_exec_ack_ignored");

        // NOP ignores a stray ack.
        step(0, 4'd9, 1, 0, 0, fetch_ack(8), "nop_fetch");
        step(0, 4'd9, 1, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8), "nop_exec");

        // Stalled FETCH then STO waiting on ack.
        step(0, 4'd1, 0, 0, 0, fetch_wait(9), "fetch_stall");
        step(0, 4'd1, 0, 0, 0, fetch_wait(9), "fetch_stall2");
        step(0, 4'd1, 1, 0, 0, fetch_ack(9), "sto_fetch");
        step(0, 4'd1, 0, 0, 0, sto_exec(9), "sto_wait");
        step(0, 4'd1, 0, 0, 0, sto_exec(9), "sto_wait2");
        step(0, 4'd1, 1, 0, 0, sto_exec(9), "sto_ack");

        // Reset mid-FETCH abandons the access and clears the count at once.
        step(0, 4'd0, 0, 0, 0, fetch_wait(10), "fetch_before_rst");
        step(1, 4'd0, 0, 0, 0, fetch_wait(0), "rst_mid_fetch");
        step(1, 4'd0, 1, 0, 0, fetch_wait(0), "rst_ack_masked");

        // STO then STP from a fresh count; HALT is absorbing.
        step(0, 4'd1, 1, 0, 0, fetch_ack(0), "sto2_fetch");
        step(0, 4'd1, 0, 0, 0, sto_exec(0), "sto2_wait");
        step(0, 4'd1, 0, 0, 0, sto_exec(0), "sto2_wait2");
        step(0, 4'd1, 1, 0, 0, sto_exec(0), "sto2_ack");
        step(0, 4'd7, 1, 0, 0, fetch_ack(1), "stp_fetch");
        step(0, 4'd7, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "stp_exec");
        for (int i = 0; i < 10; i++)
            step(0, 4'(i), 1, i[0], ~i[0], ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2), "halt_hold");

        step(1, 4'd0, 1, 0, 0, fetch_wait(0), "rst_from_halt");
        step(0, 4'd0, 0, 0, 0, fetch_wait(0), "fetch_after_halt_rst");

        // Counter wrap on the preloaded instance running NOPs.
        rst_w = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wq.push_back(wrap_exp[i]);
            @(posedge clk);
            #1;
        end

        @(posedge clk);
        #1;
        check("queues_drained", 32'(q.size() + wq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
